// File: rtl/pulp_io_l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pulp_io_l2_arbiter
// Brief    : Round-robin, request-locking arbiter sharing one L2 req/gnt/rvalid
//            port; an ID FIFO routes in-order responses back to the requester.
//            Optional macro PULP_IO_L2_ARB_PRIO0_EN: requester 0 strict priority.
// Revision : 1.0
// ============================================================================
module pulp_io_l2_arbiter #(
  parameter int N_REQ           = 3,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              sys_clk_i,
  input  logic                              sys_rst_ni,
  input  logic [N_REQ-1:0]                  req_i,
  input  logic [N_REQ-1:0]                  wen_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0]       addr_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]       wdata_i,
  input  logic [N_REQ*DATA_WIDTH/8-1:0]     be_i,
  output logic [N_REQ-1:0]                  gnt_o,
  output logic [N_REQ-1:0]                  rvalid_o,
  output logic [DATA_WIDTH-1:0]             rdata_o,
  output logic                              L2_req_o,
  output logic                              L2_wen_o,
  output logic [ADDR_WIDTH-1:0]             L2_addr_o,
  output logic [DATA_WIDTH-1:0]             L2_wdata_o,
  output logic [DATA_WIDTH/8-1:0]           L2_be_o,
  input  logic                              L2_gnt_i,
  input  logic                              L2_rvalid_i,
  input  logic [DATA_WIDTH-1:0]             L2_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_o,
  output logic                              err_o
);

  localparam int c_ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int c_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int c_CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int c_BE_W  = DATA_WIDTH / 8;
  localparam logic [c_ID_W-1:0]  c_ID_LAST  = c_ID_W'(N_REQ - 1);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(MAX_OUTSTANDING);

  logic [c_ID_W-1:0]  r_rr;
  logic               r_lock;
  logic [c_ID_W-1:0]  r_lock_idx;
  logic [c_ID_W-1:0]  r_fifo [MAX_OUTSTANDING];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_err;

  logic               w_any_req;
  logic               w_full;
  logic               w_empty;
  logic               w_found;
  logic [c_ID_W-1:0]  w_sel;
  logic [c_ID_W-1:0]  w_cand;
  logic [c_ID_W-1:0]  w_head;
  logic               w_hs;
  logic               w_pop;
  logic               w_wen;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [c_BE_W-1:0]     w_be;
  int                 w_idx;

  assign w_any_req = |req_i;
  assign w_full    = (r_count == c_CNT_FULL);
  assign w_empty   = (r_count == '0);
  assign w_head    = r_fifo[r_rptr];
  assign L2_req_o  = w_any_req & ~w_full;
  assign w_hs      = L2_req_o & L2_gnt_i;
  assign w_pop     = L2_rvalid_i & ~w_empty;

  // A held lock overrides both the round-robin scan and requester-0 priority.
  always_comb begin
    w_sel   = r_lock ? r_lock_idx : '0;
    w_found = r_lock;
    w_idx   = 0;
    w_cand  = '0;
`ifdef PULP_IO_L2_ARB_PRIO0_EN
    if (!w_found && req_i[0]) begin
      w_sel   = '0;
      w_found = 1'b1;
    end
`endif
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = int'(r_rr) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      w_cand = c_ID_W'(w_idx);
      if (!w_found && req_i[w_cand]) begin
        w_sel   = w_cand;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_wen   = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    w_be    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_sel == c_ID_W'(i)) begin
        w_wen   = wen_i[i];
        w_addr  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_wdata = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        w_be    = be_i[i*c_BE_W +: c_BE_W];
      end
    end
  end

  assign L2_wen_o   = w_any_req & w_wen;
  assign L2_addr_o  = w_any_req ? w_addr  : '0;
  assign L2_wdata_o = w_any_req ? w_wdata : '0;
  assign L2_be_o    = w_any_req ? w_be    : '0;

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt_o[i]    = w_hs  && (w_sel  == c_ID_W'(i));
      rvalid_o[i] = w_pop && (w_head == c_ID_W'(i));
    end
  end

  assign rdata_o       = w_pop ? L2_rdata_i : '0;
  assign outstanding_o = r_count;
  assign err_o         = r_err;

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      r_rr       <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_err      <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_fifo[i] <= '0;
    end else begin
      if (w_hs) begin
        r_lock         <= 1'b0;
        r_fifo[r_wptr] <= w_sel;
        r_wptr         <= (r_wptr == c_PTR_LAST) ? '0 : r_wptr + c_PTR_W'(1);
`ifdef PULP_IO_L2_ARB_PRIO0_EN
        if (w_sel != '0)
          r_rr <= (w_sel == c_ID_LAST) ? '0 : w_sel + c_ID_W'(1);
`else
        r_rr <= (w_sel == c_ID_LAST) ? '0 : w_sel + c_ID_W'(1);
`endif
      end else if (L2_req_o) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_sel;
      end
      if (w_pop) r_rptr <= (r_rptr == c_PTR_LAST) ? '0 : r_rptr + c_PTR_W'(1);
      if (w_hs && !w_pop) r_count <= r_count + c_CNT_W'(1);
      else if (!w_hs && w_pop) r_count <= r_count - c_CNT_W'(1);
      if (L2_rvalid_i && w_empty) r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulp_io_l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulp_io_l2_arbiter
// Brief    : Directed self-checking bench for pulp_io_l2_arbiter (3 requesters).
// Revision : 1.0
// ============================================================================
module tb_pulp_io_l2_arbiter;

  localparam logic [31:0] ADDR0 = 32'h1C00_0100;
  localparam logic [31:0] ADDR1 = 32'h1C00_0200;
  localparam logic [31:0] ADDR2 = 32'h1C00_0300;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0, wen = '0;
  logic [95:0] addr = {ADDR2, ADDR1, ADDR0};
  logic [95:0] wdata = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
  logic [11:0] be = 12'hFFF;
  logic [2:0]  gnt_o, rvalid_o;
  logic [31:0] rdata_o;
  logic        L2_req_o, L2_wen_o;
  logic [31:0] L2_addr_o, L2_wdata_o;
  logic [3:0]  L2_be_o;
  logic        L2_gnt = 1'b0, L2_rvalid = 1'b0;
  logic [31:0] L2_rdata = '0;
  logic [2:0]  outstanding_o;
  logic        err_o;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pulp_io_l2_arbiter #(
    .N_REQ(3), .DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_OUTSTANDING(4)
  ) dut (
    .sys_clk_i(clk), .sys_rst_ni(rst_n),
    .req_i(req), .wen_i(wen), .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .L2_req_o(L2_req_o), .L2_wen_o(L2_wen_o), .L2_addr_o(L2_addr_o),
    .L2_wdata_o(L2_wdata_o), .L2_be_o(L2_be_o),
    .L2_gnt_i(L2_gnt), .L2_rvalid_i(L2_rvalid), .L2_rdata_i(L2_rdata),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    req = '0; wen = '0; L2_gnt = 1'b0; L2_rvalid = 1'b0; L2_rdata = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = '0; L2_gnt = 1'b0; L2_rvalid = 1'b0; rst_n = 1'b0;
    #1;
    n_total++; if (gnt_o !== 3'b000) $display("FAIL rst_gnt: got %b exp 000", gnt_o); else n_pass++;
    n_total++; if (rvalid_o !== 3'b000) $display("FAIL rst_rvalid: got %b exp 000", rvalid_o); else n_pass++;
    n_total++; if (L2_req_o !== 1'b0) $display("FAIL rst_l2req: got %b exp 0", L2_req_o); else n_pass++;
    n_total++; if (L2_addr_o !== 32'h0) $display("FAIL rst_l2addr: got %h exp 0", L2_addr_o); else n_pass++;
    n_total++; if (outstanding_o !== 3'd0) $display("FAIL rst_outst: got %0d exp 0", outstanding_o); else n_pass++;
    n_total++; if (err_o !== 1'b0) $display("FAIL rst_err: got %b exp 0", err_o); else n_pass++;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    req = 3'b001; wen = 3'b001; L2_gnt = 1'b1;
    #1;
    n_total++; if (gnt_o !== 3'b001) $display("FAIL t1_gnt: got %b exp 001", gnt_o); else n_pass++;
    n_total++; if (L2_req_o !== 1'b1) $display("FAIL t1_l2req: got %b exp 1", L2_req_o); else n_pass++;
    n_total++; if (L2_addr_o !== ADDR0) $display("FAIL t1_addr: got %h exp %h", L2_addr_o, ADDR0); else n_pass++;
    n_total++; if (L2_wen_o !== 1'b1) $display("FAIL t1_wen: got %b exp 1", L2_wen_o); else n_pass++;
    tick();
    req = '0; L2_gnt = 1'b0; L2_rvalid = 1'b1; L2_rdata = 32'hDEAD_BEEF;
    #1;
    n_total++; if (outstanding_o !== 3'd1) $display("FAIL t1_outst: got %0d exp 1", outstanding_o); else n_pass++;
    n_total++; if (rvalid_o !== 3'b001) $display("FAIL t1_rvalid: got %b exp 001", rvalid_o); else n_pass++;
    n_total++; if (rdata_o !== 32'hDEAD_BEEF) $display("FAIL t1_rdata: got %h exp deadbeef", rdata_o); else n_pass++;
    tick();
    L2_rvalid = 1'b0;
    #1;
    n_total++; if (outstanding_o !== 3'd0) $display("FAIL t1_drain: got %0d exp 0", outstanding_o); else n_pass++;
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g, prev_g;
    prev_g = '0;
    do_reset();
    req = 3'b111; wen = 3'b111; L2_gnt = 1'b1;
    for (int i = 0; i < 6; i++) begin
`ifdef PULP_IO_L2_ARB_PRIO0_EN
      exp_g = 3'b001;
`else
      exp_g = 3'b001 << (i % 3);
`endif
      L2_rvalid = (i > 0);
      L2_rdata  = 32'hA000_0000 + 32'(i);
      #1;
      n_total++; if (gnt_o !== exp_g) $display("FAIL t2_gnt[%0d]: got %b exp %b", i, gnt_o, exp_g); else n_pass++;
      if (i > 0) begin
        n_total++; if (rvalid_o !== prev_g) $display("FAIL t2_rvalid[%0d]: got %b exp %b", i, rvalid_o, prev_g); else n_pass++;
        n_total++; if (outstanding_o !== 3'd1) $display("FAIL t2_outst[%0d]: got %0d exp 1", i, outstanding_o); else n_pass++;
      end
      prev_g = exp_g;
      tick();
    end
    req = '0; L2_gnt = 1'b0; L2_rvalid = 1'b1; L2_rdata = 32'hA000_0006;
    #1;
    n_total++; if (rvalid_o !== prev_g) $display("FAIL t2_last_rvalid: got %b exp %b", rvalid_o, prev_g); else n_pass++;
    n_total++; if (rdata_o !== 32'hA000_0006) $display("FAIL t2_last_rdata: got %h exp a0000006", rdata_o); else n_pass++;
    tick();
    L2_rvalid = 1'b0;
    #1;
    n_total++; if (outstanding_o !== 3'd0) $display("FAIL t2_drain: got %0d exp 0", outstanding_o); else n_pass++;
    tick();
  endtask

  task automatic test_lock();
    do_reset();
    req = 3'b011; wen = 3'b000; L2_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_total++; if (L2_addr_o !== ADDR0) $display("FAIL t3_addr_wait[%0d]: got %h exp %h", c, L2_addr_o, ADDR0); else n_pass++;
      n_total++; if (gnt_o !== 3'b000) $display("FAIL t3_gnt_wait[%0d]: got %b exp 000", c, gnt_o); else n_pass++;
      tick();
    end
    L2_gnt = 1'b1;
    #1;
    n_total++; if (L2_addr_o !== ADDR0) $display("FAIL t3_addr_gnt: got %h exp %h", L2_addr_o, ADDR0); else n_pass++;
    n_total++; if (gnt_o !== 3'b001) $display("FAIL t3_gnt0: got %b exp 001", gnt_o); else n_pass++;
    tick();
    #1;
    n_total++; if (gnt_o !== 3'b010) $display("FAIL t3_gnt1: got %b exp 010", gnt_o); else n_pass++;
    n_total++; if (L2_addr_o !== ADDR1) $display("FAIL t3_addr1: got %h exp %h", L2_addr_o, ADDR1); else n_pass++;
    tick();
    req = '0; L2_gnt = 1'b0; L2_rvalid = 1'b1;
    #1;
    n_total++; if (rvalid_o !== 3'b001) $display("FAIL t3_rv0: got %b exp 001", rvalid_o); else n_pass++;
    tick();
    #1;
    n_total++; if (rvalid_o !== 3'b010) $display("FAIL t3_rv1: got %b exp 010", rvalid_o); else n_pass++;
    tick();
    // rr now points at 2: a late request from 2 must not steal the locked requester 0.
    L2_rvalid = 1'b0; req = 3'b001;
    tick();
    req = 3'b101;
    #1;
    n_total++; if (L2_addr_o !== ADDR0) $display("FAIL t3_lock_addr: got %h exp %h", L2_addr_o, ADDR0); else n_pass++;
    tick();
    L2_gnt = 1'b1;
    #1;
    n_total++; if (gnt_o !== 3'b001) $display("FAIL t3_lock_gnt: got %b exp 001", gnt_o); else n_pass++;
    tick();
    req = '0; L2_gnt = 1'b0; L2_rvalid = 1'b1;
    #1;
    n_total++; if (rvalid_o !== 3'b001) $display("FAIL t3_lock_rv: got %b exp 001", rvalid_o); else n_pass++;
    tick();
    L2_rvalid = 1'b0;
    tick();
  endtask

  task automatic test_full();
    logic [2:0] g [4];
    logic [2:0] g_res;
    logic [2:0] drain [4];
`ifdef PULP_IO_L2_ARB_PRIO0_EN
    g[0] = 3'b001; g[1] = 3'b001; g[2] = 3'b001; g[3] = 3'b001; g_res = 3'b001;
`else
    g[0] = 3'b001; g[1] = 3'b010; g[2] = 3'b100; g[3] = 3'b001; g_res = 3'b010;
`endif
    drain[0] = g[1]; drain[1] = g[2]; drain[2] = g[3]; drain[3] = g_res;
    do_reset();
    req = 3'b111; wen = 3'b111; L2_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++; if (gnt_o !== g[i]) $display("FAIL t4_gnt[%0d]: got %b exp %b", i, gnt_o, g[i]); else n_pass++;
      n_total++; if (outstanding_o !== 3'(i)) $display("FAIL t4_outst[%0d]: got %0d exp %0d", i, outstanding_o, i); else n_pass++;
      tick();
    end
    #1;
    n_total++; if (outstanding_o !== 3'd4) $display("FAIL t4_full_outst: got %0d exp 4", outstanding_o); else n_pass++;
    n_total++; if (L2_req_o !== 1'b0) $display("FAIL t4_full_req: got %b exp 0", L2_req_o); else n_pass++;
    n_total++; if (gnt_o !== 3'b000) $display("FAIL t4_full_gnt: got %b exp 000", gnt_o); else n_pass++;
    tick();
    L2_rvalid = 1'b1; L2_rdata = 32'h0000_0055;
    #1;
    n_total++; if (rvalid_o !== g[0]) $display("FAIL t4_pop_rv: got %b exp %b", rvalid_o, g[0]); else n_pass++;
    n_total++; if (L2_req_o !== 1'b0) $display("FAIL t4_pop_req: got %b exp 0", L2_req_o); else n_pass++;
    n_total++; if (gnt_o !== 3'b000) $display("FAIL t4_pop_gnt: got %b exp 000", gnt_o); else n_pass++;
    tick();
    L2_rvalid = 1'b0;
    #1;
    n_total++; if (L2_req_o !== 1'b1) $display("FAIL t4_resume_req: got %b exp 1", L2_req_o); else n_pass++;
    n_total++; if (gnt_o !== g_res) $display("FAIL t4_resume_gnt: got %b exp %b", gnt_o, g_res); else n_pass++;
    n_total++; if (outstanding_o !== 3'd3) $display("FAIL t4_resume_outst: got %0d exp 3", outstanding_o); else n_pass++;
    tick();
    req = '0; L2_gnt = 1'b0;
    for (int j = 0; j < 4; j++) begin
      L2_rvalid = 1'b1;
      #1;
      n_total++; if (rvalid_o !== drain[j]) $display("FAIL t4_drain_rv[%0d]: got %b exp %b", j, rvalid_o, drain[j]); else n_pass++;
      tick();
    end
    L2_rvalid = 1'b0;
    #1;
    n_total++; if (outstanding_o !== 3'd0) $display("FAIL t4_empty: got %0d exp 0", outstanding_o); else n_pass++;
    n_total++; if (err_o !== 1'b0) $display("FAIL t4_err: got %b exp 0", err_o); else n_pass++;
    tick();
  endtask

  task automatic test_err();
    do_reset();
    L2_rvalid = 1'b1; L2_rdata = 32'h1234_5678;
    #1;
    n_total++; if (rvalid_o !== 3'b000) $display("FAIL t5_rv: got %b exp 000", rvalid_o); else n_pass++;
    tick();
    L2_rvalid = 1'b0;
    #1;
    n_total++; if (err_o !== 1'b1) $display("FAIL t5_err_set: got %b exp 1", err_o); else n_pass++;
    tick();
    tick();
    #1;
    n_total++; if (err_o !== 1'b1) $display("FAIL t5_err_sticky: got %b exp 1", err_o); else n_pass++;
    do_reset();
    #1;
    n_total++; if (err_o !== 1'b0) $display("FAIL t5_err_clear: got %b exp 0", err_o); else n_pass++;
    tick();
    req = 3'b001; L2_gnt = 1'b1;
    tick();
    req = '0; L2_gnt = 1'b0;
    #1;
    n_total++; if (outstanding_o !== 3'd1) $display("FAIL t5_pre_rst: got %0d exp 1", outstanding_o); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_total++; if (outstanding_o !== 3'd0) $display("FAIL t5_async_rst: got %0d exp 0", outstanding_o); else n_pass++;
    tick();
    rst_n = 1'b1; L2_rvalid = 1'b1;
    #1;
    n_total++; if (rvalid_o !== 3'b000) $display("FAIL t5_flight_rv: got %b exp 000", rvalid_o); else n_pass++;
    tick();
    L2_rvalid = 1'b0;
    #1;
    n_total++; if (err_o !== 1'b1) $display("FAIL t5_flight_err: got %b exp 1", err_o); else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_full();
    test_err();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
